// File: rtl/scr1_dmi_pkg.sv
// DMI scan channel shared definitions: op/status codes, channel ids, DTMCS layout.
package scr1_dmi_pkg;

  localparam int unsigned SCR1_DMI_AWIDTH  = 7;
  localparam int unsigned SCR1_DMI_DWIDTH  = 32;
  localparam int unsigned SCR1_DMI_OPWIDTH = 2;

  typedef enum logic [1:0] {
    DMI_OP_NOP = 2'd0,
    DMI_OP_RD  = 2'd1,
    DMI_OP_WR  = 2'd2,
    DMI_OP_RSV = 2'd3
  } dmi_op_e;

  localparam logic [1:0] DMI_STATUS_OK   = 2'd0;
  localparam logic [1:0] DMI_STATUS_BUSY = 2'd3;

  localparam logic [1:0] SCR1_DBG_DMI_CH_ID_DTMCS     = 2'd1;
  localparam logic [1:0] SCR1_DBG_DMI_CH_ID_DMIACCESS = 2'd2;

  // DTMCS register layout
  localparam int unsigned DTMCS_WIDTH            = 32;
  localparam int unsigned DTMCS_VERSION_LSB      = 0;
  localparam int unsigned DTMCS_ABITS_LSB        = 4;
  localparam int unsigned DTMCS_DMISTAT_LSB      = 10;
  localparam int unsigned DTMCS_DMIRESET_BIT     = 16;
  localparam int unsigned DTMCS_DMIHARDRESET_BIT = 17;
  localparam logic [3:0]  DTMCS_VERSION          = 4'd1;

  typedef enum logic {
    StIdle,
    StBusy
  } dmi_state_e;

endpackage

// File: rtl/scr1_dmi_dtmcs_fmt.sv
// DTMCS capture word builder and update-field decoder (purely combinational).
module scr1_dmi_dtmcs_fmt
  import scr1_dmi_pkg::*;
#(
  parameter int unsigned DMI_AWIDTH = 7
) (
  input  logic        busy_err_i,
  input  logic [1:0]  upd_ctrl_i,   // {dmihardreset, dmireset} from the shift register
  output logic [31:0] cap_word_o,
  output logic        dmireset_o,
  output logic        dmihardreset_o
);

  // Assemble the DTMCS word; all fields not listed read as zero
  always_comb begin
    cap_word_o = '0;
    cap_word_o[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
    cap_word_o[DTMCS_ABITS_LSB +: 6]   = 6'(DMI_AWIDTH);
    cap_word_o[DTMCS_DMISTAT_LSB +: 2] = busy_err_i ? DMI_STATUS_BUSY : DMI_STATUS_OK;
  end

  assign dmireset_o     = upd_ctrl_i[0];
  assign dmihardreset_o = upd_ctrl_i[1];

endmodule

// File: rtl/scr1_dmi_scan_ch.sv
// Core-clock end of the JTAG debug channel: DTMCS/DMI_ACCESS shift register and DM request FSM.
module scr1_dmi_scan_ch
  import scr1_dmi_pkg::*;
#(
  parameter int unsigned DMI_AWIDTH  = SCR1_DMI_AWIDTH,
  parameter int unsigned DMI_DWIDTH  = SCR1_DMI_DWIDTH,
  parameter int unsigned DMI_OPWIDTH = SCR1_DMI_OPWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_sel_i,
  input  logic [1:0]            ch_id_i,
  input  logic                  ch_capture_i,
  input  logic                  ch_shift_i,
  input  logic                  ch_update_i,
  input  logic                  ch_tdi_i,
  output logic                  ch_tdo_o,
  output logic                  dmi_req_o,
  output logic                  dmi_wr_o,
  output logic [DMI_AWIDTH-1:0] dmi_addr_o,
  output logic [DMI_DWIDTH-1:0] dmi_wdata_o,
  input  logic                  dmi_resp_i,
  input  logic [DMI_DWIDTH-1:0] dmi_rdata_i
);

  localparam int unsigned SR = DMI_AWIDTH + DMI_DWIDTH + DMI_OPWIDTH;

  logic [SR-1:0]         shreg_q;
  logic [DMI_AWIDTH-1:0] addr_q;
  logic [DMI_DWIDTH-1:0] rdata_q;
  logic                  busy_err_q;
  dmi_state_e            state_q;

  logic                  is_dtmcs;
  logic                  is_dmi;
  logic                  cap;
  logic                  sft;
  logic                  upd;
  logic [1:0]            dmi_status;
  logic [31:0]           dtmcs_word;
  logic                  dmireset;
  logic                  dmihardreset;
  logic [1:0]            upd_op;
  logic                  upd_hardreset;

  // Strobe qualification; capture beats shift beats update within a cycle
  always_comb begin
    is_dtmcs   = ch_sel_i & (ch_id_i == SCR1_DBG_DMI_CH_ID_DTMCS);
    is_dmi     = ch_sel_i & (ch_id_i == SCR1_DBG_DMI_CH_ID_DMIACCESS);
    cap        = (is_dtmcs | is_dmi) & ch_capture_i;
    sft        = (is_dtmcs | is_dmi) & ch_shift_i & ~ch_capture_i;
    upd        = (is_dtmcs | is_dmi) & ch_update_i & ~ch_capture_i & ~ch_shift_i;
    dmi_status = ((state_q == StBusy) || busy_err_q) ? DMI_STATUS_BUSY : DMI_STATUS_OK;
    upd_op     = shreg_q[1:0];
    upd_hardreset = upd & is_dtmcs & dmihardreset;
  end

  scr1_dmi_dtmcs_fmt #(
    .DMI_AWIDTH (DMI_AWIDTH)
  ) i_dtmcs_fmt (
    .busy_err_i     (busy_err_q),
    .upd_ctrl_i     (shreg_q[DTMCS_DMIHARDRESET_BIT:DTMCS_DMIRESET_BIT]),
    .cap_word_o     (dtmcs_word),
    .dmireset_o     (dmireset),
    .dmihardreset_o (dmihardreset)
  );

  // Shift register: parallel capture or serial shift (DTMCS uses only the low 32 bits)
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (cap) begin
      if (is_dtmcs) shreg_q <= {{(SR-DTMCS_WIDTH){1'b0}}, dtmcs_word};
      else          shreg_q <= {addr_q, rdata_q, dmi_status};
    end else if (sft) begin
      if (is_dtmcs) shreg_q[DTMCS_WIDTH-1:0] <= {ch_tdi_i, shreg_q[DTMCS_WIDTH-1:1]};
      else          shreg_q <= {ch_tdi_i, shreg_q[SR-1:1]};
    end
  end

  assign ch_tdo_o = shreg_q[0];

  // DM request FSM; a later update overrides the response completion in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dmi_req_o   <= 1'b0;
      dmi_wr_o    <= 1'b0;
      addr_q      <= '0;
      dmi_wdata_o <= '0;
      rdata_q     <= '0;
      busy_err_q  <= 1'b0;
    end else begin
      // A hard reset in the same cycle discards the response as well
      if ((state_q == StBusy) && dmi_resp_i && !upd_hardreset) begin
        state_q   <= StIdle;
        dmi_req_o <= 1'b0;
        if (!dmi_wr_o) rdata_q <= dmi_rdata_i;
      end
      if (upd && is_dtmcs) begin
        if (dmireset || dmihardreset) busy_err_q <= 1'b0;
        if (dmihardreset) begin
          state_q   <= StIdle;
          dmi_req_o <= 1'b0;
        end
      end
      if (upd && is_dmi) begin
        if ((state_q == StBusy) || busy_err_q) begin
          busy_err_q <= 1'b1;
        end else if ((upd_op == DMI_OP_RD) || (upd_op == DMI_OP_WR)) begin
          state_q     <= StBusy;
          dmi_req_o   <= 1'b1;
          dmi_wr_o    <= (upd_op == DMI_OP_WR);
          addr_q      <= shreg_q[SR-1 -: DMI_AWIDTH];
          dmi_wdata_o <= shreg_q[DMI_OPWIDTH +: DMI_DWIDTH];
        end
      end
    end
  end

  assign dmi_addr_o = addr_q;

endmodule

// File: tb/tb_scr1_dmi_scan_ch.sv
// Directed self-checking bench for scr1_dmi_scan_ch.
module tb_scr1_dmi_scan_ch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_sel_i = 1'b0;
  logic [1:0]  ch_id_i = 2'd0;
  logic        ch_capture_i = 1'b0;
  logic        ch_shift_i = 1'b0;
  logic        ch_update_i = 1'b0;
  logic        ch_tdi_i = 1'b0;
  logic        ch_tdo_o;
  logic        dmi_req_o;
  logic        dmi_wr_o;
  logic [6:0]  dmi_addr_o;
  logic [31:0] dmi_wdata_o;
  logic        dmi_resp_i = 1'b0;
  logic [31:0] dmi_rdata_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scr1_dmi_scan_ch dut (
    .clk          (clk),
    .rst          (rst),
    .ch_sel_i     (ch_sel_i),
    .ch_id_i      (ch_id_i),
    .ch_capture_i (ch_capture_i),
    .ch_shift_i   (ch_shift_i),
    .ch_update_i  (ch_update_i),
    .ch_tdi_i     (ch_tdi_i),
    .ch_tdo_o     (ch_tdo_o),
    .dmi_req_o    (dmi_req_o),
    .dmi_wr_o     (dmi_wr_o),
    .dmi_addr_o   (dmi_addr_o),
    .dmi_wdata_o  (dmi_wdata_o),
    .dmi_resp_i   (dmi_resp_i),
    .dmi_rdata_i  (dmi_rdata_i)
  );

  // ---------------- stimulus helpers (inputs change on negedge) ----------------
  task automatic do_capture(input logic sel, input logic [1:0] id);
    @(negedge clk); ch_sel_i = sel; ch_id_i = id; ch_capture_i = 1'b1;
    @(negedge clk); ch_capture_i = 1'b0;
  endtask

  task automatic do_update(input logic sel, input logic [1:0] id);
    @(negedge clk); ch_sel_i = sel; ch_id_i = id; ch_update_i = 1'b1;
    @(negedge clk); ch_update_i = 1'b0;
  endtask

  // Shift n bits LSB first, collecting tdo before each shift edge
  task automatic do_shift(input logic sel, input logic [1:0] id, input int n,
                          input logic [40:0] din, output logic [40:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dout[i] = ch_tdo_o;
      ch_sel_i = sel; ch_id_i = id; ch_tdi_i = din[i]; ch_shift_i = 1'b1;
    end
    @(negedge clk); ch_shift_i = 1'b0; ch_tdi_i = 1'b0;
  endtask

  task automatic pulse_resp(input logic [31:0] rd);
    @(negedge clk); dmi_resp_i = 1'b1; dmi_rdata_i = rd;
    @(negedge clk); dmi_resp_i = 1'b0; dmi_rdata_i = '0;
  endtask

  task automatic issue_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    logic [40:0] junk;
    do_shift(1'b1, 2'd2, 41, {a, d, op}, junk);
    do_update(1'b1, 2'd2);
  endtask

  task automatic read_dmi(output logic [40:0] v);
    do_capture(1'b1, 2'd2);
    do_shift(1'b1, 2'd2, 41, 41'd0, v);
  endtask

  task automatic read_dtmcs(output logic [31:0] v);
    logic [40:0] t;
    do_capture(1'b1, 2'd1);
    do_shift(1'b1, 2'd1, 32, 41'd0, t);
    v = t[31:0];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [40:0] v;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", dmi_req_o); end
    n_cmp++; if ({dmi_wr_o, dmi_addr_o, dmi_wdata_o} !== 40'd0) begin n_err++;
      $display("FAIL reset_outs got %h want 0", {dmi_wr_o, dmi_addr_o, dmi_wdata_o}); end
    n_cmp++; if (ch_tdo_o !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b want 0", ch_tdo_o); end
    read_dmi(v);
    n_cmp++; if (v !== 41'd0) begin n_err++; $display("FAIL reset_dmi_cap got %h want 0", v); end
  endtask

  task automatic test_dtmcs_capture();
    logic [31:0] v;
    read_dtmcs(v);
    n_cmp++; if (v !== 32'h0000_0071) begin n_err++; $display("FAIL dtmcs_cap got %h want 00000071", v); end
  endtask

  task automatic test_read();
    logic [40:0] v;
    issue_req(7'h10, 32'h0, 2'd1);
    n_cmp++; if (dmi_req_o !== 1'b1) begin n_err++; $display("FAIL rd_req_rise got %b want 1", dmi_req_o); end
    n_cmp++; if (dmi_wr_o !== 1'b0) begin n_err++; $display("FAIL rd_wr got %b want 0", dmi_wr_o); end
    n_cmp++; if (dmi_addr_o !== 7'h10) begin n_err++; $display("FAIL rd_addr got %h want 10", dmi_addr_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (dmi_req_o !== 1'b1) begin n_err++; $display("FAIL rd_req_hold%0d got %b want 1", i, dmi_req_o); end
    end
    pulse_resp(32'hDEAD_BEEF);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL rd_req_fall got %b want 0", dmi_req_o); end
    read_dmi(v);
    n_cmp++; if (v !== {7'h10, 32'hDEAD_BEEF, 2'b00}) begin n_err++;
      $display("FAIL rd_cap got %h want %h", v, {7'h10, 32'hDEAD_BEEF, 2'b00}); end
  endtask

  task automatic test_write();
    logic [40:0] v;
    issue_req(7'h04, 32'h1234_5678, 2'd2);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({dmi_req_o, dmi_wr_o, dmi_addr_o, dmi_wdata_o} !== {1'b1, 1'b1, 7'h04, 32'h1234_5678}) begin
        n_err++; $display("FAIL wr_stable%0d got %h want %h", i, {dmi_req_o, dmi_wr_o, dmi_addr_o, dmi_wdata_o},
                          {1'b1, 1'b1, 7'h04, 32'h1234_5678}); end
      @(negedge clk);
    end
    pulse_resp(32'hCAFE_F00D);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL wr_req_fall got %b want 0", dmi_req_o); end
    read_dmi(v);
    n_cmp++; if (v !== {7'h04, 32'hDEAD_BEEF, 2'b00}) begin n_err++;
      $display("FAIL wr_cap got %h want %h", v, {7'h04, 32'hDEAD_BEEF, 2'b00}); end
  endtask

  task automatic test_busy();
    logic [40:0] v;
    logic [31:0] d;
    logic [40:0] junk;
    issue_req(7'h20, 32'h0, 2'd1);
    issue_req(7'h30, 32'h0, 2'd1);
    n_cmp++; if ({dmi_req_o, dmi_addr_o} !== {1'b1, 7'h20}) begin n_err++;
      $display("FAIL busy_no_new_req got %h want %h", {dmi_req_o, dmi_addr_o}, {1'b1, 7'h20}); end
    read_dmi(v);
    n_cmp++; if (v !== {7'h20, 32'hDEAD_BEEF, 2'b11}) begin n_err++;
      $display("FAIL busy_cap got %h want %h", v, {7'h20, 32'hDEAD_BEEF, 2'b11}); end
    pulse_resp(32'h1122_3344);
    read_dmi(v);
    n_cmp++; if (v !== {7'h20, 32'h1122_3344, 2'b11}) begin n_err++;
      $display("FAIL busy_sticky got %h want %h", v, {7'h20, 32'h1122_3344, 2'b11}); end
    read_dtmcs(d);
    n_cmp++; if (d !== 32'h0000_0C71) begin n_err++; $display("FAIL busy_dmistat got %h want 00000c71", d); end
    do_shift(1'b1, 2'd1, 32, 41'h0_0001_0000, junk);
    do_update(1'b1, 2'd1);
    read_dmi(v);
    n_cmp++; if (v !== {7'h20, 32'h1122_3344, 2'b00}) begin n_err++;
      $display("FAIL dmireset got %h want %h", v, {7'h20, 32'h1122_3344, 2'b00}); end
  endtask

  task automatic test_hardreset();
    logic [40:0] v;
    logic [40:0] junk;
    issue_req(7'h05, 32'h0, 2'd1);
    n_cmp++; if (dmi_req_o !== 1'b1) begin n_err++; $display("FAIL hr_req_rise got %b want 1", dmi_req_o); end
    do_shift(1'b1, 2'd1, 32, 41'h0_0002_0000, junk);
    do_update(1'b1, 2'd1);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL hr_req_drop got %b want 0", dmi_req_o); end
    pulse_resp(32'h9999_9999);
    read_dmi(v);
    n_cmp++; if (v !== {7'h05, 32'h1122_3344, 2'b00}) begin n_err++;
      $display("FAIL hr_late_resp got %h want %h", v, {7'h05, 32'h1122_3344, 2'b00}); end
    issue_req(7'h06, 32'h0, 2'd1);
    n_cmp++; if ({dmi_req_o, dmi_addr_o} !== {1'b1, 7'h06}) begin n_err++;
      $display("FAIL hr_idle_again got %h want %h", {dmi_req_o, dmi_addr_o}, {1'b1, 7'h06}); end
    pulse_resp(32'hA5A5_A5A5);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL hr_final_resp got %b want 0", dmi_req_o); end
  endtask

  task automatic test_reset_mid_and_sel();
    logic [40:0] v;
    logic [40:0] junk;
    logic [40:0] pat;
    issue_req(7'h07, 32'h0, 2'd1);
    n_cmp++; if (dmi_req_o !== 1'b1) begin n_err++; $display("FAIL rm_req_rise got %b want 1", dmi_req_o); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if ({dmi_req_o, dmi_wr_o, dmi_addr_o, dmi_wdata_o, ch_tdo_o} !== 42'd0) begin n_err++;
      $display("FAIL rm_outs got %h want 0", {dmi_req_o, dmi_wr_o, dmi_addr_o, dmi_wdata_o, ch_tdo_o}); end
    pulse_resp(32'h7777_7777);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL rm_late_resp got %b want 0", dmi_req_o); end
    // Load a pattern whose op field is a write, then hit it with deselected strobes
    pat = {7'h55, 32'hC3C3_A5A5, 2'b10};
    do_shift(1'b1, 2'd2, 41, pat, junk);
    do_capture(1'b0, 2'd2);
    do_shift(1'b0, 2'd2, 5, 41'h1F, junk);
    do_capture(1'b1, 2'd0);
    do_update(1'b0, 2'd2);
    n_cmp++; if (dmi_req_o !== 1'b0) begin n_err++; $display("FAIL sel0_update got %b want 0", dmi_req_o); end
    do_shift(1'b1, 2'd2, 41, 41'd0, v);
    n_cmp++; if (v !== pat) begin n_err++; $display("FAIL sel0_shreg got %h want %h", v, pat); end
  endtask

  initial begin
    test_reset();
    test_dtmcs_capture();
    test_read();
    test_write();
    test_busy();
    test_hardreset();
    test_reset_mid_and_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
